vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing and test-pattern generator: the next generation of the fixed 640x480 `vga_sync`. Every horizontal and vertical timing field, sync polarity and colour width is a parameter. It adds a pixel-enable input, pixel coordinate outputs, data-enable, and frame/line strobes. It also has four selectable pattern modes, so a display can be brought up before any frame source exists. It sits between the clock/reset block and the top-level RED/GRN/BLU/HSYNC/VSYNC pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- R_W, 3, red width
- G_W, 3, green width
- B_W, 2, blue width
- CW, 11, counter and coordinate width

Ports:
- app_clk  in  1  pixel-domain clock; the only clock
- app_srst  in  1  reset, synchronous, active-high
- en  in  1  pixel advance enable; tie high when app_clk equals the pixel rate
- mode  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 grid
- solid_rgb  in  R_W+G_W+B_W  colour for mode 0, packed {r,g,b}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video flag
- x  out  CW  pixel column
- y  out  CW  pixel line
- frame_start  out  1  strobe at pixel (0,0)
- line_start  out  1  strobe at h=0 of every line
- red  out  R_W  red
- green  out  G_W  green
- blue  out  B_W  blue

## Operation
- Line and frame totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters: h counts 0..H_TOTAL-1 and increments when en=1. On wrap, h returns to 0 and v increments, 0..V_TOTAL-1. h=0, v=0 is the first active pixel.
- Counter ranges: active when h<H_ACTIVE and v<V_ACTIVE. hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Sync output level is HS_POL/VS_POL when active and the inverse otherwise.
- x and y carry h and v while de=1; both are 0 when de=0.
- Mode latching: mode and solid_rgb are sampled only on the en cycle where h=0 and v=0, and are also loaded at reset. A change mid-frame takes effect on the next frame.
- Patterns (only while de=1; r/g/b=0 when de=0; "full" means all ones, "off" means 0):
  - Mode 0: solid_rgb.
  - Mode 1: bar index i = h/(H_ACTIVE/8), computed with compare boundaries, no divider. Colours for i=0..7: white, yellow, cyan, green, magenta, red, blue, black. Each channel is full or off.
  - Mode 2: white when h[5]^v[5]=0, black otherwise.
  - Mode 3: white when h[3:0]=0, v[3:0]=0, h=H_ACTIVE-1 or v=V_ACTIVE-1; black otherwise.
- en=0 stalls: counters and hsync, vsync, de, x, y, rgb hold; frame_start and line_start drive 0.

## Timing
- Latency: all outputs are registered. Outputs in cycle t+1 reflect the counter state in the en cycle t; one cycle of latency, uniform across every output.
- Strobes: frame_start and line_start are high for exactly one cycle per occurrence, aligned with the de rising edge of pixel (0,0) and (0,v).
- Reset values (app_srst sampled high): h=v=0; mode latch=reset value of mode; de=0; x=y=0; rgb=0; hsync=~HS_POL; vsync=~VS_POL; strobes 0.
- First frame after reset: the first en=1 cycle after reset produces outputs for (0,0) on the following edge, with frame_start=1.
- Reset mid-frame: takes effect on the next edge regardless of en and restarts at (0,0). There is no partial-line recovery.
- Wrap: (H_TOTAL-1, V_TOTAL-1) is followed by (0,0) with no gap cycle.

## Test plan
- Reset hold 5 cycles, defaults: hsync=1, vsync=1, de=0, rgb=0. First en cycle after release gives frame_start=1 and de=1 one cycle later; x=0, y=0.
- en=1 continuously: frame_start period = 420000 cycles, line_start period = 800. hsync low for 96 cycles starting 656 cycles after line_start. vsync low for 2 lines starting at line 490. de high for 640 cycles per line on lines 0..479 only.
- mode=1, line 10:
  - x=0..79 gives 7/7/3.
  - x=80 gives 7/7/0 (yellow).
  - x=560..639 gives 0/0/0.
  - h>=640 gives rgb=0.
- mode=2: (31,0) white, (32,0) black, (32,32) white. Switch to mode=3 at line 200: no change until the next frame_start, then (16,5)=white and (17,5)=black.
- en alternating 1/0 (50 MHz clock): frame_start period = 840000 cycles. Outputs hold on en=0 cycles; strobes are never high on two consecutive cycles.
- app_srst pulsed at (300,200): next outputs restart at (0,0) with frame_start=1. Non-default parameters (H_ACTIVE=800, V_ACTIVE=600, 800x600@60 porches, HS_POL=1) give line period 1056 and an active-high hsync of 128.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: pacing and pattern controls in,
// sync, coordinates, strobes and colour out.
interface vga_timing_gen_if #(
  parameter int R_W = 3,
  parameter int G_W = 3,
  parameter int B_W = 2,
  parameter int CW  = 11
);
  logic                   en;
  logic [1:0]             mode;
  logic [R_W+G_W+B_W-1:0] solid_rgb;
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic [CW-1:0]          x;
  logic [CW-1:0]          y;
  logic                   frame_start;
  logic                   line_start;
  logic [R_W-1:0]         red;
  logic [G_W-1:0]         green;
  logic [B_W-1:0]         blue;

  modport master (
    output en, mode, solid_rgb,
    input  hsync, vsync, de, x, y, frame_start, line_start, red, green, blue
  );

  modport slave (
    input  en, mode, solid_rgb,
    output hsync, vsync, de, x, y, frame_start, line_start, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing with four built-in test patterns; every output
// is registered one pixel after the counter position it describes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int CW       = 11
) (
  input  logic            app_clk,
  input  logic            app_srst,
  vga_timing_gen_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int RGB_W   = R_W + G_W + B_W;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EDGE_C = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_EDGE_C = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]    h_r;
  logic [CW-1:0]    v_r;
  logic [1:0]       mode_r;
  logic [RGB_W-1:0] solid_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             de_r;
  logic [CW-1:0]    x_r;
  logic [CW-1:0]    y_r;
  logic             fs_r;
  logic             ls_r;
  logic [R_W-1:0]   red_r;
  logic [G_W-1:0]   green_r;
  logic [B_W-1:0]   blue_r;

  logic             origin_s;
  logic             active_s;
  logic             hs_act_s;
  logic             vs_act_s;
  logic             checker_s;
  logic             grid_s;
  logic [1:0]       mode_s;
  logic [RGB_W-1:0] solid_s;
  logic [2:0]       bar_s;
  logic [R_W-1:0]   r_s;
  logic [G_W-1:0]   g_s;
  logic [B_W-1:0]   b_s;

  // Position decode; at the frame origin the live mode inputs apply to the whole new frame
  always_comb begin
    origin_s  = (h_r == ZERO_C) && (v_r == ZERO_C);
    active_s  = (h_r < H_ACT_C) && (v_r < V_ACT_C);
    hs_act_s  = (h_r >= HS_BEG_C) && (h_r < HS_END_C);
    vs_act_s  = (v_r >= VS_BEG_C) && (v_r < VS_END_C);
    checker_s = ~(h_r[5] ^ v_r[5]);
    grid_s    = (h_r[3:0] == 4'd0) || (v_r[3:0] == 4'd0) ||
                (h_r == H_EDGE_C) || (v_r == V_EDGE_C);
    if (origin_s) begin
      mode_s  = bus.mode;
      solid_s = bus.solid_rgb;
    end else begin
      mode_s  = mode_r;
      solid_s = solid_r;
    end
  end

  // Bar index as a thermometer count of passed bar boundaries
  always_comb begin
    bar_s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      bar_s = bar_s + {2'b00, (h_r >= CW'(k * BAR_W))};
    end
  end

  // Pattern colour; bar colours follow the inverted index bits (white..black order)
  always_comb begin
    r_s = {R_W{1'b0}};
    g_s = {G_W{1'b0}};
    b_s = {B_W{1'b0}};
    if (active_s) begin
      case (mode_s)
        2'd0: begin
          r_s = solid_s[RGB_W-1 -: R_W];
          g_s = solid_s[G_W+B_W-1 -: G_W];
          b_s = solid_s[B_W-1:0];
        end
        2'd1: begin
          r_s = {R_W{~bar_s[1]}};
          g_s = {G_W{~bar_s[2]}};
          b_s = {B_W{~bar_s[0]}};
        end
        2'd2: begin
          r_s = {R_W{checker_s}};
          g_s = {G_W{checker_s}};
          b_s = {B_W{checker_s}};
        end
        2'd3: begin
          r_s = {R_W{grid_s}};
          g_s = {G_W{grid_s}};
          b_s = {B_W{grid_s}};
        end
        default: begin
          r_s = {R_W{1'b0}};
          g_s = {G_W{1'b0}};
          b_s = {B_W{1'b0}};
        end
      endcase
    end else begin
      r_s = {R_W{1'b0}};
      g_s = {G_W{1'b0}};
      b_s = {B_W{1'b0}};
    end
  end

  // Raster counters, per-frame mode latch and the registered output stage
  always_ff @(posedge app_clk) begin
    if (app_srst) begin
      h_r     <= ZERO_C;
      v_r     <= ZERO_C;
      mode_r  <= bus.mode;
      solid_r <= bus.solid_rgb;
      hsync_r <= ~HS_POL;
      vsync_r <= ~VS_POL;
      de_r    <= 1'b0;
      x_r     <= ZERO_C;
      y_r     <= ZERO_C;
      fs_r    <= 1'b0;
      ls_r    <= 1'b0;
      red_r   <= {R_W{1'b0}};
      green_r <= {G_W{1'b0}};
      blue_r  <= {B_W{1'b0}};
    end else if (bus.en) begin
      if (h_r == H_LAST_C) begin
        h_r <= ZERO_C;
        if (v_r == V_LAST_C) begin
          v_r <= ZERO_C;
        end else begin
          v_r <= v_r + ONE_C;
        end
      end else begin
        h_r <= h_r + ONE_C;
      end
      mode_r  <= mode_s;
      solid_r <= solid_s;
      hsync_r <= hs_act_s ? HS_POL : ~HS_POL;
      vsync_r <= vs_act_s ? VS_POL : ~VS_POL;
      de_r    <= active_s;
      x_r     <= active_s ? h_r : ZERO_C;
      y_r     <= active_s ? v_r : ZERO_C;
      fs_r    <= origin_s;
      ls_r    <= (h_r == ZERO_C);
      red_r   <= r_s;
      green_r <= g_s;
      blue_r  <= b_s;
    end else begin
      fs_r <= 1'b0;
      ls_r <= 1'b0;
    end
  end

  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
  assign bus.de          = de_r;
  assign bus.x           = x_r;
  assign bus.y           = y_r;
  assign bus.frame_start = fs_r;
  assign bus.line_start  = ls_r;
  assign bus.red         = red_r;
  assign bus.green       = green_r;
  assign bus.blue        = blue_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster; expectations come from
// an arithmetic pixel-index model, checked cycle by cycle by a separate monitor.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 80;
  localparam int H_FP     = 6;
  localparam int H_SYNC   = 10;
  localparam int H_BP     = 8;
  localparam int V_ACTIVE = 40;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 5;
  localparam bit HS_POL   = 1'b1;
  localparam bit VS_POL   = 1'b0;
  localparam int R_W      = 3;
  localparam int G_W      = 3;
  localparam int B_W      = 2;
  localparam int CW       = 11;
  localparam int RGB_W    = R_W + G_W + B_W;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int SEG_LEN  = 4000;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          fs;
    logic          ls;
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } out_t;

  logic clk;
  logic app_srst;

  vga_timing_gen_if #(.R_W(R_W), .G_W(G_W), .B_W(B_W), .CW(CW)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL),
    .R_W(R_W), .G_W(G_W), .B_W(B_W), .CW(CW)
  ) dut (
    .app_clk (clk),
    .app_srst(app_srst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  out_t             sb_q[$];
  out_t             last_exp;
  int               pix;
  logic [1:0]       lat_mode;
  logic [RGB_W-1:0] lat_solid;
  int               checks = 0;
  int               errors = 0;

  // Bar colours white, yellow, cyan, green, magenta, red, blue, black as {r,g,b}
  function automatic logic [2:0] bar_colour(input int i);
    case (i)
      0:       return 3'b111;
      1:       return 3'b110;
      2:       return 3'b011;
      3:       return 3'b010;
      4:       return 3'b101;
      5:       return 3'b100;
      6:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic out_t reset_out();
    out_t o;
    o    = '0;
    o.hs = !HS_POL;
    o.vs = !VS_POL;
    return o;
  endfunction

  function automatic out_t model(input int h, input int v, input logic [1:0] m,
                                 input logic [RGB_W-1:0] c);
    out_t       o;
    bit         act;
    logic [2:0] rgb;
    act  = (h < H_ACTIVE) && (v < V_ACTIVE);
    o    = '0;
    o.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
    o.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
    o.de = act;
    o.x  = act ? CW'(h) : '0;
    o.y  = act ? CW'(v) : '0;
    o.fs = (h == 0) && (v == 0);
    o.ls = (h == 0);
    rgb  = 3'b000;
    if (act) begin
      if (m == 2'd0) begin
        {o.r, o.g, o.b} = c;
      end else begin
        if (m == 2'd1) rgb = bar_colour(h / (H_ACTIVE / 8));
        else if (m == 2'd2) rgb = (((h / 32) % 2) == ((v / 32) % 2)) ? 3'b111 : 3'b000;
        else rgb = ((h % 16 == 0) || (v % 16 == 0) || (h == H_ACTIVE - 1) ||
                    (v == V_ACTIVE - 1)) ? 3'b111 : 3'b000;
        o.r = rgb[2] ? '1 : '0;
        o.g = rgb[1] ? '1 : '0;
        o.b = rgb[0] ? '1 : '0;
      end
    end
    return o;
  endfunction

  // Drive one cycle of stimulus and queue the output it must produce
  task automatic drive(input logic s, input logic e, input logic [1:0] m,
                       input logic [RGB_W-1:0] c);
    int h;
    int v;
    @(negedge clk);
    app_srst      = s;
    bus.en        = e;
    bus.mode      = m;
    bus.solid_rgb = c;
    if (s) begin
      pix       = 0;
      lat_mode  = m;
      lat_solid = c;
      last_exp  = reset_out();
    end else if (e) begin
      h = pix % H_TOTAL;
      v = (pix / H_TOTAL) % V_TOTAL;
      if (h == 0 && v == 0) begin
        lat_mode  = m;
        lat_solid = c;
      end
      last_exp = model(h, v, lat_mode, lat_solid);
      pix++;
    end else begin
      last_exp.fs = 1'b0;
      last_exp.ls = 1'b0;
    end
    sb_q.push_back(last_exp);
  endtask

  function automatic logic [1:0] seg_mode(input int seg);
    case (seg)
      0: return 2'd0;
      1: return 2'd1;
      2: return 2'd2;
      3: return 2'd3;
      4: return 2'd3;
      5: return 2'd2;
      6: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Monitor: compare every presented output against the queue head, plus raw periods
  int cyc       = 0;
  int last_fs   = 0;
  int last_ls   = 0;
  bit fs_seen   = 1'b0;
  bit ls_seen   = 1'b0;
  bit fs_clean  = 1'b0;
  bit ls_clean  = 1'b0;
  initial begin
    out_t a;
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        a.hs = bus.hsync;
        a.vs = bus.vsync;
        a.de = bus.de;
        a.x  = bus.x;
        a.y  = bus.y;
        a.fs = bus.frame_start;
        a.ls = bus.line_start;
        a.r  = bus.red;
        a.g  = bus.green;
        a.b  = bus.blue;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL pixel_out cycle=%0d actual=%h expected=%h (hs vs de x y fs ls r g b)",
                   cyc, a, e);
        end
        if (app_srst || !bus.en) begin
          fs_clean = 1'b0;
          ls_clean = 1'b0;
        end
        if (bus.frame_start === 1'b1) begin
          if (fs_seen && fs_clean) begin
            checks++;
            if (cyc - last_fs != FRAME) begin
              errors++;
              $display("FAIL frame_period actual=%0d expected=%0d", cyc - last_fs, FRAME);
            end
          end
          fs_seen  = 1'b1;
          fs_clean = 1'b1;
          last_fs  = cyc;
        end
        if (bus.line_start === 1'b1) begin
          if (ls_seen && ls_clean) begin
            checks++;
            if (cyc - last_ls != H_TOTAL) begin
              errors++;
              $display("FAIL line_period actual=%0d expected=%0d", cyc - last_ls, H_TOTAL);
            end
          end
          ls_seen  = 1'b1;
          ls_clean = 1'b1;
          last_ls  = cyc;
        end
      end
    end
  end

  initial begin
    logic [1:0]       m;
    logic [RGB_W-1:0] c;
    logic             e;
    logic             s;
    app_srst      = 1'b1;
    bus.en        = 1'b0;
    bus.mode      = 2'd1;
    bus.solid_rgb = '0;
    pix           = 0;
    lat_mode      = 2'd1;
    lat_solid     = '0;
    last_exp      = reset_out();

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 2'd1, RGB_W'($urandom));
    end

    // Segments: continuous en, random en with a mid-frame reset, then alternating en
    for (int seg = 0; seg < 8; seg++) begin
      m = seg_mode(seg);
      c = RGB_W'($urandom);
      for (int i = 0; i < SEG_LEN; i++) begin
        if (seg < 3) e = 1'b1;
        else if (seg < 6) e = ($urandom_range(0, 3) != 0);
        else e = ((i % 2) == 0);
        s = (seg == 5) && (i >= 2000) && (i < 2003);
        if (s) e = 1'($urandom_range(0, 1));
        drive(s, e, m, c);
      end
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d pending expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
